// File: rtl/toothless_pkg.sv
// Shared definitions for the data-memory responder slice.
//   mem_state_e  : responder FSM states
//   BE_*         : common byte-enable patterns for word-aligned accesses
//   MEM_WAIT_MAX : largest supported number of wait states
package toothless_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_HALF0 = 4'b0011;
  localparam logic [3:0] BE_HALF1 = 4'b1100;
  localparam logic [3:0] BE_WORD  = 4'b1111;

  localparam int MEM_WAIT_MAX = 15;

endpackage

// File: rtl/data_mem_array.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port. Contents are never reset; only the read register is.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (read register only)
//   wr_en      : write the enabled byte lanes of wdata into word idx
//   rd_en      : load word idx into rdata
//   rd_clr     : force rdata to zero (used for faulted accesses)
//   idx        : word index
//   be         : byte-lane enables, bit n = lane n
//   wdata      : lane-aligned write data
//   rdata      : registered read data, holds between reads
module data_mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             rd_clr,
  input  logic [IDX_W-1:0] idx,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      rdata <= '0;
    else if (rd_clr) rdata <= '0;
    else if (rd_en)  rdata <= mem[idx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the core's data-memory request interface.
//
// Handshake: the requester raises req_i and holds we_i/addr_i/be_i/wdata_i
// stable until gnt_o; a cycle with req_i && gnt_o high transfers the request
// on the following clock edge (the grant edge). Exactly one rvalid_o strobe
// follows each grant, WAIT_CYCLES+1 cycles after the grant edge, carrying
// rdata_o and err_o. A new request may be granted in the response cycle.
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   req_i      : request valid
//   gnt_o      : request accepted this cycle (combinational)
//   we_i       : 1 = store, 0 = load
//   addr_i     : byte address
//   be_i       : store byte enables (ignored for loads)
//   wdata_i    : lane-aligned store data
//   rvalid_o   : one-cycle response strobe
//   rdata_o    : load data, valid with rvalid_o, held otherwise
//   err_o      : access fault, valid with rvalid_o
module data_mem_responder
  import toothless_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [3:0]            be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o
);

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mem_state_e state;
  logic [3:0] wait_cnt;

  // Request fields captured on the grant edge, used when wait states delay
  // the commit past the point where the requester still holds them.
  logic                  cap_we;
  logic                  cap_fault;
  logic [IDX_W-1:0]      cap_idx;
  logic [3:0]            cap_be;
  logic [DATA_WIDTH-1:0] cap_wdata;

  // Address decode of the live request.
  logic [ADDR_WIDTH-1:0] byte_off;
  logic [ADDR_WIDTH-1:0] word_off;
  logic                  live_fault;
  logic [IDX_W-1:0]      live_idx;

  assign byte_off   = addr_i - BASE_ADDR;
  assign word_off   = byte_off >> 2;
  assign live_fault = (addr_i[1:0] != 2'b00) || (addr_i < BASE_ADDR) ||
                      (word_off >= ADDR_WIDTH'(DEPTH_WORDS));
  assign live_idx   = word_off[IDX_W-1:0];

  assign gnt_o = req_i && rst_n && ((state == IDLE) || (state == RESP));

  // Commit happens on the edge entering RESP. With no wait states that is
  // the grant edge itself, so the live request fields are used directly.
  logic                  commit;
  logic                  c_we;
  logic                  c_fault;
  logic [IDX_W-1:0]      c_idx;
  logic [3:0]            c_be;
  logic [DATA_WIDTH-1:0] c_wdata;

  always_comb begin
    commit  = 1'b0;
    c_we    = cap_we;
    c_fault = cap_fault;
    c_idx   = cap_idx;
    c_be    = cap_be;
    c_wdata = cap_wdata;
    if (WAIT_CYCLES == 0) begin
      commit  = gnt_o;
      c_we    = we_i;
      c_fault = live_fault;
      c_idx   = live_idx;
      c_be    = be_i;
      c_wdata = wdata_i;
    end else begin
      commit = rst_n && (state == WAIT) && (wait_cnt == 4'd0);
    end
  end

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (commit && c_we && !c_fault),
    .rd_en  (commit && !c_we && !c_fault),
    .rd_clr (commit && c_fault),
    .idx    (c_idx),
    .be     (c_be),
    .wdata  (c_wdata),
    .rdata  (rdata_o)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      rvalid_o  <= 1'b0;
      err_o     <= 1'b0;
      cap_we    <= 1'b0;
      cap_fault <= 1'b0;
      cap_idx   <= '0;
      cap_be    <= 4'd0;
      cap_wdata <= '0;
    end else begin
      rvalid_o <= commit;
      err_o    <= commit && c_fault;
      case (state)
        IDLE, RESP: begin
          if (gnt_o) begin
            cap_we    <= we_i;
            cap_fault <= live_fault;
            cap_idx   <= live_idx;
            cap_be    <= be_i;
            cap_wdata <= wdata_i;
            if (WAIT_CYCLES > 0) begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end else begin
              state <= RESP;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  import toothless_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // index 0: WAIT_CYCLES=0, 1: WAIT_CYCLES=3, 2: WAIT_CYCLES=2
  logic [2:0]       req = '0;
  logic [2:0]       gnt;
  logic [2:0]       we = '0;
  logic [2:0][31:0] addr = '0;
  logic [2:0][3:0]  be = '0;
  logic [2:0][31:0] wdata = '0;
  logic [2:0]       rvalid;
  logic [2:0][31:0] rdata;
  logic [2:0]       err;

  int checks = 0;
  int failures = 0;

  data_mem_responder #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .we_i(we[0]),
    .addr_i(addr[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_o(err[0]));

  data_mem_responder #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .we_i(we[1]),
    .addr_i(addr[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_o(err[1]));

  data_mem_responder #(.WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .we_i(we[2]),
    .addr_i(addr[2]), .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]),
    .rdata_o(rdata[2]), .err_o(err[2]));

  // ---------------- driver ----------------
  // One complete transaction on responder d. gw = cycles spent waiting for
  // grant, lat = cycles from grant edge to the rvalid strobe.
  task automatic xact(input int d, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] wd,
                      output logic [31:0] rd, output logic e,
                      output int lat, output int gw);
    rd = '0; e = 1'b0; lat = -1; gw = 0;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    #1;
    while (!gnt[d] && gw < 20) begin
      @(negedge clk); #1; gw++;
    end
    if (!gnt[d]) begin
      checks++; failures++;
      $display("FAIL grant_timeout dut=%0d addr=%h got no grant in 20 cycles", d, a);
      req[d] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req[d] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rvalid[d]) begin
        lat = k; rd = rdata[d]; e = err[d];
        break;
      end
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL rvalid_timeout dut=%0d addr=%h no response in 20 cycles", d, a);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    req = 3'b111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (gnt[d] !== 1'b0) begin
        failures++; $display("FAIL reset_gnt dut=%0d got=%b exp=0", d, gnt[d]);
      end
      checks++;
      if (rvalid[d] !== 1'b0 || err[d] !== 1'b0) begin
        failures++; $display("FAIL reset_rvalid_err dut=%0d got=%b%b exp=00", d, rvalid[d], err[d]);
      end
      checks++;
      if (rdata[d] !== 32'h0) begin
        failures++; $display("FAIL reset_rdata dut=%0d got=%h exp=00000000", d, rdata[d]);
      end
    end
    req = 3'b000;
    rst_n = 1'b1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic e; int lat, gw;
    xact(0, 1'b1, 32'h10, BE_WORD, 32'hDEADBEEF, rd, e, lat, gw);
    checks++;
    if (gw !== 0 || lat !== 1 || e !== 1'b0) begin
      failures++; $display("FAIL store_timing got gw=%0d lat=%0d err=%b exp gw=0 lat=1 err=0", gw, lat, e);
    end
    xact(0, 1'b0, 32'h10, 4'b0000, 32'h0, rd, e, lat, gw);
    checks++;
    if (gw !== 0 || lat !== 1 || e !== 1'b0) begin
      failures++; $display("FAIL load_timing got gw=%0d lat=%0d err=%b exp gw=0 lat=1 err=0", gw, lat, e);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      failures++; $display("FAIL load_data got=%h exp=deadbeef", rd);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rdata[0] !== 32'hDEADBEEF || rvalid[0] !== 1'b0 || err[0] !== 1'b0) begin
      failures++; $display("FAIL rdata_hold got rdata=%h rvalid=%b err=%b exp deadbeef 0 0",
                           rdata[0], rvalid[0], err[0]);
    end
  endtask

  task automatic test_byte_enables();
    logic [31:0] rd; logic e; int lat, gw;
    xact(0, 1'b1, 32'h10, BE_BYTE0, 32'h000000AA, rd, e, lat, gw);
    xact(0, 1'b1, 32'h10, BE_HALF1, 32'h55660000, rd, e, lat, gw);
    xact(0, 1'b0, 32'h10, BE_WORD, 32'h0, rd, e, lat, gw);
    checks++;
    if (rd !== 32'h5566BEAA || e !== 1'b0) begin
      failures++; $display("FAIL byte_lanes got=%h err=%b exp=5566beaa err=0", rd, e);
    end
    // Zero byte enables: normal completion, nothing written.
    xact(0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, rd, e, lat, gw);
    checks++;
    if (e !== 1'b0 || lat !== 1) begin
      failures++; $display("FAIL be_zero_resp got err=%b lat=%0d exp err=0 lat=1", e, lat);
    end
    xact(0, 1'b0, 32'h10, BE_HALF0, 32'h0, rd, e, lat, gw);
    checks++;
    if (rd !== 32'h5566BEAA) begin
      failures++; $display("FAIL be_zero_nowrite got=%h exp=5566beaa", rd);
    end
  endtask

  task automatic test_faults();
    logic [31:0] rd; logic e; int lat, gw;
    xact(0, 1'b1, 32'h0, BE_WORD, 32'h0BADC0DE, rd, e, lat, gw);
    xact(0, 1'b0, 32'h0, BE_WORD, 32'h0, rd, e, lat, gw);
    checks++;
    if (rd !== 32'h0BADC0DE || e !== 1'b0) begin
      failures++; $display("FAIL word0_init got=%h err=%b exp=0badc0de err=0", rd, e);
    end
    xact(0, 1'b0, 32'h13, BE_WORD, 32'h0, rd, e, lat, gw);
    checks++;
    if (e !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
      failures++; $display("FAIL misaligned_load got err=%b rdata=%h lat=%0d exp err=1 rdata=0 lat=1", e, rd, lat);
    end
    xact(0, 1'b1, 32'h1000, BE_WORD, 32'hFFFF0000, rd, e, lat, gw);
    checks++;
    if (e !== 1'b1) begin
      failures++; $display("FAIL range_store_err got=%b exp=1", e);
    end
    xact(0, 1'b0, 32'h0, BE_WORD, 32'h0, rd, e, lat, gw);
    checks++;
    if (rd !== 32'h0BADC0DE || e !== 1'b0) begin
      failures++; $display("FAIL range_store_nowrite got=%h err=%b exp=0badc0de err=0", rd, e);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h8; be[0] = BE_WORD; wdata[0] = 32'h12345678;
    #1;
    checks++;
    if (gnt[0] !== 1'b1) begin
      failures++; $display("FAIL b2b_store_gnt got=%b exp=1", gnt[0]);
    end
    @(posedge clk); #1;
    we[0] = 1'b0; wdata[0] = 32'h0;   // same address, now a load, during store RESP
    @(negedge clk);
    checks++;
    if (rvalid[0] !== 1'b1 || err[0] !== 1'b0 || gnt[0] !== 1'b1) begin
      failures++; $display("FAIL b2b_store_resp got rvalid=%b err=%b gnt=%b exp 1 0 1",
                           rvalid[0], err[0], gnt[0]);
    end
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h12345678) begin
      failures++; $display("FAIL b2b_load_resp got rvalid=%b rdata=%h exp 1 12345678", rvalid[0], rdata[0]);
    end
    @(negedge clk);
    checks++;
    if (rvalid[0] !== 1'b0) begin
      failures++; $display("FAIL b2b_strobe_end got rvalid=%b exp=0", rvalid[0]);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic e; int lat, gw;
    bit seen;
    xact(1, 1'b1, 32'h20, BE_WORD, 32'hA5A50020, rd, e, lat, gw);
    checks++;
    if (lat !== 4 || e !== 1'b0) begin
      failures++; $display("FAIL wait_store_lat got lat=%0d err=%b exp lat=4 err=0", lat, e);
    end
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h20; be[1] = BE_WORD;
    #1;
    checks++;
    if (gnt[1] !== 1'b1) begin
      failures++; $display("FAIL wait_load_gnt got=%b exp=1", gnt[1]);
    end
    @(posedge clk); #1;
    addr[1] = 32'h24;   // second request held high throughout WAIT
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (gnt[1] !== 1'b0 || rvalid[1] !== 1'b0) begin
        failures++; $display("FAIL wait_no_grant cycle=%0d got gnt=%b rvalid=%b exp 0 0", k, gnt[1], rvalid[1]);
      end
    end
    @(negedge clk);
    checks++;
    if (rvalid[1] !== 1'b1 || rdata[1] !== 32'hA5A50020 || err[1] !== 1'b0) begin
      failures++; $display("FAIL wait_load_resp got rvalid=%b rdata=%h err=%b exp 1 a5a50020 0",
                           rvalid[1], rdata[1], err[1]);
    end
    checks++;
    if (gnt[1] !== 1'b1) begin
      failures++; $display("FAIL wait_resp_gnt got=%b exp=1", gnt[1]);
    end
    @(posedge clk); #1;
    req[1] = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rvalid[1]) begin
        seen = 1'b1;
        lat = k;
        break;
      end
    end
    checks++;
    if (!seen || lat !== 4) begin
      failures++; $display("FAIL wait_second_resp got seen=%b lat=%0d exp seen=1 lat=4", seen, lat);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic e; int lat, gw;
    bit seen;
    xact(2, 1'b1, 32'h4, BE_WORD, 32'h11112222, rd, e, lat, gw);
    checks++;
    if (lat !== 3) begin
      failures++; $display("FAIL w2_store_lat got=%0d exp=3", lat);
    end
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h4; be[2] = BE_WORD; wdata[2] = 32'hCAFEF00D;
    #1;
    checks++;
    if (gnt[2] !== 1'b1) begin
      failures++; $display("FAIL rmw_gnt got=%b exp=1", gnt[2]);
    end
    @(posedge clk); #1;
    req[2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rvalid[2]) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rvalid[2]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL rmw_no_rvalid got=%b exp=0", seen);
    end
    xact(2, 1'b0, 32'h4, BE_WORD, 32'h0, rd, e, lat, gw);
    checks++;
    if (rd !== 32'h11112222 || e !== 1'b0) begin
      failures++; $display("FAIL rmw_no_write got=%h err=%b exp=11112222 err=0", rd, e);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_store_load();
    test_byte_enables();
    test_faults();
    test_back_to_back();
    test_wait_states();
    test_reset_mid_wait();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
